// File: rtl/codec_config_sequencer_if.sv
// Serial-writer handshake between the config sequencer (master) and the I2C writer (slave).
interface codec_config_sequencer_if;
    logic [23:0] I2C_DATA;
    logic        GO;
    logic        W_R;
    logic        END;
    logic        ACK;

    modport master (output I2C_DATA, GO, W_R, input END, ACK);
    modport slave  (input I2C_DATA, GO, W_R, output END, ACK);
endinterface

// File: rtl/codec_config_sequencer.sv
// WM8731 power-up sequencer: walks an 11-entry register table, one 24-bit I2C write
// per entry, retrying NACKed or timed-out writes before reporting DONE or ERROR.
module codec_config_sequencer #(
    parameter logic [7:0]  SLAVE_ADDR    = 8'h34,
    parameter logic [15:0] POWERUP_DELAY = 16'd2000,
    parameter int unsigned MAX_RETRIES   = 2,
    parameter logic [5:0]  XFER_TIMEOUT  = 6'd48
) (
    input  logic                     CLOCK,
    input  logic                     RESET,
    input  logic                     START,
    codec_config_sequencer_if.master i2c,
    output logic [3:0]               INDEX,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERROR
);
    typedef enum logic [3:0] {
        ST_POWERUP_WAIT, ST_LOAD, ST_ARM, ST_XFER, ST_CHECK,
        ST_RETRY, ST_NEXT, ST_DONE, ST_FAIL
    } state_t;

    localparam logic [3:0] LAST_INDEX = 4'd10;

    state_t      state;
    logic [15:0] dly_cnt;
    logic [5:0]  tmo_cnt;
    logic [3:0]  retry_cnt;

    // Register words {addr[6:0], data[8:0]}; reset first, activate last.
    function automatic logic [15:0] reg_word(input logic [3:0] idx);
        case (idx)
            4'd0:    reg_word = 16'h1E00;
            4'd1:    reg_word = 16'h0017;
            4'd2:    reg_word = 16'h0217;
            4'd3:    reg_word = 16'h0479;
            4'd4:    reg_word = 16'h0679;
            4'd5:    reg_word = 16'h0812;
            4'd6:    reg_word = 16'h0A00;
            4'd7:    reg_word = 16'h0C00;
            4'd8:    reg_word = 16'h0E02;
            4'd9:    reg_word = 16'h1000;
            default: reg_word = 16'h1201;
        endcase
    endfunction

    assign i2c.W_R = 1'b0;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state        <= ST_POWERUP_WAIT;
            dly_cnt      <= '0;
            tmo_cnt      <= '0;
            retry_cnt    <= '0;
            i2c.GO       <= 1'b0;
            i2c.I2C_DATA <= {SLAVE_ADDR, 16'h1E00};
            INDEX        <= '0;
            BUSY         <= 1'b1;
            DONE         <= 1'b0;
            ERROR        <= 1'b0;
        end else begin
            case (state)
                ST_POWERUP_WAIT: begin
                    if (dly_cnt == POWERUP_DELAY - 16'd1) state <= ST_LOAD;
                    else dly_cnt <= dly_cnt + 16'd1;
                end
                ST_LOAD: begin
                    i2c.I2C_DATA <= {SLAVE_ADDR, reg_word(INDEX)};
                    i2c.GO       <= 1'b0;
                    state        <= ST_ARM;
                end
                // END low means the writer saw GO low long enough to re-arm.
                ST_ARM: begin
                    if (!i2c.END) begin
                        i2c.GO  <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (i2c.END) begin
                        state <= ST_CHECK;
                    end else if (tmo_cnt == XFER_TIMEOUT - 6'd1) begin
                        i2c.GO <= 1'b0;
                        state  <= ST_RETRY;
                    end else begin
                        tmo_cnt <= tmo_cnt + 6'd1;
                    end
                end
                // GO is still high here so the writer keeps END/ACK valid.
                ST_CHECK: begin
                    i2c.GO <= 1'b0;
                    state  <= i2c.ACK ? ST_RETRY : ST_NEXT;
                end
                ST_RETRY: begin
                    if ({28'd0, retry_cnt} < MAX_RETRIES) begin
                        retry_cnt <= retry_cnt + 4'd1;
                        state     <= ST_LOAD;
                    end else begin
                        BUSY  <= 1'b0;
                        ERROR <= 1'b1;
                        state <= ST_FAIL;
                    end
                end
                ST_NEXT: begin
                    retry_cnt <= '0;
                    if (INDEX == LAST_INDEX) begin
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        INDEX <= INDEX + 4'd1;
                        state <= ST_LOAD;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    if (START) begin
                        DONE      <= 1'b0;
                        ERROR     <= 1'b0;
                        BUSY      <= 1'b1;
                        INDEX     <= '0;
                        retry_cnt <= '0;
                        state     <= ST_LOAD;
                    end
                end
                default: state <= ST_POWERUP_WAIT;
            endcase
        end
    end
endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Upstream control stage for the I2C serial writer; produces its `I2C_DATA`, `GO` and `W_R` inputs and consumes its `END` and `ACK` outputs.
- After reset and a power-up delay, walks a fixed 11-entry WM8731 register table and issues one 24-bit I2C write per entry.
- Retries NACKed or timed-out writes, then reports `DONE` or `ERROR` to the audio-path control logic.
- Runs on the same slow I2C bit clock as the serial writer.

Parameters:
- `SLAVE_ADDR`, `8'h34`, 8-bit codec write address placed in `I2C_DATA[23:16]`.
- `POWERUP_DELAY`, `16'd2000`, `CLOCK` cycles to wait before the first transfer.
- `MAX_RETRIES`, `2`, extra attempts per entry after the first failure.
- `XFER_TIMEOUT`, `6'd48`, max cycles in `XFER` waiting for `END`.

Ports:
- `CLOCK`  in  1  I2C bit clock, shared with the serial writer.
- `RESET`  in  1  synchronous, active-high reset.
- `START`  in  1  one-cycle pulse; re-runs the table, honoured only in `DONE` or `FAIL`.
- `END`  in  1  from serial writer; 1 = idle or transfer finished.
- `ACK`  in  1  from serial writer; 1 = any of the three ACK slots saw NACK.
- `I2C_DATA`  out  24  `{SLAVE_ADDR, table[INDEX]}` to the serial writer.
- `GO`  out  1  transfer request; low re-arms the serial writer.
- `W_R`  out  1  constant 0 (write).
- `INDEX`  out  4  current table entry, 0..10.
- `BUSY`  out  1  high in every state except `DONE` and `FAIL`.
- `DONE`  out  1  all 11 entries written and ACKed.
- `ERROR`  out  1  an entry exhausted its retries.

Behaviour:
- Table (reg word = `{addr[6:0], data[8:0]}`), indices 0..10: `1E00` (reset), `0017`, `0217` (L/R line in 0 dB), `0479`, `0679` (L/R HP 0 dB), `0812` (DAC select, mic mute), `0A00`, `0C00` (all powered), `0E02` (I2S 16-bit slave), `1000` (48 kHz normal), `1201` (active). Index 0 must precede all others; index 10 must be last.
- Reset (synchronous, checked before all other logic):
  - state ← `POWERUP_WAIT`; delay counter ← 0.
  - `GO`=0, `INDEX`=0, `I2C_DATA`={`SLAVE_ADDR`,`16'h1E00`}.
  - `DONE`=0, `ERROR`=0, `BUSY`=1, retry count ← 0.
  - Reset mid-transfer drops `GO` on the next edge; the in-flight write is abandoned and the table restarts from 0.
- `POWERUP_WAIT`: counts `POWERUP_DELAY` cycles with `GO`=0, then goes to `LOAD`.
- `LOAD`: one cycle. Registers `I2C_DATA` from the current `INDEX`; `GO`=0; goes to `ARM`.
- `ARM`: `GO`=0. Stays until `END`==0 is sampled, which means the serial writer has re-armed; this takes 2 cycles after `GO` falls. Then goes to `XFER`. `I2C_DATA` is stable from `LOAD` through `CHECK`.
- `XFER`: `GO`=1. Timeout counter is cleared on entry.
  - On `END`==1 → `CHECK`.
  - If the counter reaches `XFER_TIMEOUT` first → counts as a failure and goes to `RETRY`; `GO` returns to 0.
- `CHECK`: `GO` stays 1 so the serial writer holds `END` and `ACK`.
  - `ACK`==0 → `NEXT`.
  - `ACK`==1 → `RETRY`.
- `RETRY`:
  - If retry count < `MAX_RETRIES`: increment it, go to `LOAD` with the same `INDEX`.
  - Otherwise go to `FAIL`.
- `NEXT`: retry count ← 0.
  - If `INDEX`==10 → `DONE`.
  - Otherwise `INDEX`++ and go to `LOAD`.
- `DONE`: `DONE`=1, `BUSY`=0, `GO`=0, `INDEX` holds at 10.
- `FAIL`: `ERROR`=1, `BUSY`=0, `GO`=0, `INDEX` holds the failing entry.
- `START` in `DONE` or `FAIL`:
  - Clears `DONE`/`ERROR`, sets `INDEX`=0 and retry count=0, goes to `LOAD` with no power-up delay.
  - `START` in any other state is ignored.
- `DONE` and `ERROR` are never high together. Both go low the cycle after an accepted `START`.
- Nominal per-entry time: 1 (`LOAD`) + 2 (`ARM`) + ~33 (`XFER`) + 1 (`CHECK`) + 1 (`NEXT`) cycles.

Test Plan:
- Reset, behavioural serial-writer model ACKs everything → 11 writes with `I2C_DATA` `341E00, 340017, … 341201` in order; `DONE`=1 about `POWERUP_DELAY`+11×38 cycles after reset; `ERROR`=0.
- Model returns `ACK`=1 once on entry 3 → entry 3 (`340479`) is sent twice, retry count clears after it; `DONE`=1, 12 transfers total.
- Model NACKs entry 5 always → exactly 3 attempts of `340812`; `ERROR`=1, `INDEX`=5, `BUSY`=0, `DONE`=0; a later `START` restarts at `341E00`.
- Model never raises `END` → each attempt times out after 48 `XFER` cycles; 3 attempts, then `FAIL`.
- `RESET` asserted during entry 7 `XFER` → `GO`=0 on the next edge; after release, `POWERUP_WAIT` is re-entered and `INDEX`=0.
- `START` pulsed while `BUSY` → no effect on sequence or `INDEX`; `START` in `DONE` → full re-run with no power-up delay.
